// File: rtl/e2prom_pkg.sv
// e2prom_bist shared types: FSM encoding, test pattern, transfer direction.
// Optional first-error log: define E2PROM_BIST_ERRLOG_EN.
package e2prom_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    WR_GAP,
    RD_REQ,
    RD_WAIT,
    CHECK,
    DONE
  } state_t;

  localparam int   T_WR_CYC = 5000;
  localparam logic I2C_RD   = 1'b1;
  localparam logic I2C_WR   = 1'b0;

  function automatic logic [7:0] pat(
    input logic [7:0] a,
    input logic [7:0] seed,
    input logic       inv
  );
    return (a + seed) ^ {8{inv}};
  endfunction

endpackage

// File: rtl/e2prom_wait_cnt.sv
// Loadable down-counter with zero flag; times the post-write gap.
// Load wins over decrement; holds at zero.
module e2prom_wait_cnt #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (en && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/e2prom_bist.sv
// EEPROM write/read-back self-test sequencer driving i2c_dri.
// Define E2PROM_BIST_ERRLOG_EN to keep the first_err_addr register.
module e2prom_bist
  import e2prom_pkg::*;
#(
  parameter int              ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int              NUM_BYTES   = 256,
  parameter logic [7:0]      SEED        = 8'h00,
  parameter bit              PAT_INV     = 1'b0,
  parameter int              WR_WAIT_CYC = T_WR_CYC,
  parameter int              MAX_RETRY   = 3,
  parameter bit              AUTO_START  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              i2c_exec,
  output logic              i2c_rh_wl,
  output logic [ADDR_W-1:0] i2c_addr,
  output logic [7:0]        i2c_data_w,
  input  logic [7:0]        i2c_data_r,
  input  logic              i2c_done,
  input  logic              i2c_ack,
  output logic              busy,
  output logic              rw_done,
  output logic              rw_result,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int CNT_W =
    (WR_WAIT_CYC < 2) ? 1 : $clog2(WR_WAIT_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BYTES - 1);
  localparam logic [3:0] RMAX = 4'(MAX_RETRY);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        retry_q;
  logic [7:0]        rdata_q;
  logic [7:0]        expect_d;
  logic [15:0]       err_q;
  logic              result_q;
  logic              boot_q;
  logic              go;
  logic              cnt_load;
  logic              gap_zero;
  logic              last;
  logic              can_retry;
  logic              mismatch;

  assign addr      = START_ADDR + idx_q;
  assign expect_d  = pat(addr[7:0], SEED, PAT_INV);
  assign last      = (idx_q == LAST);
  assign can_retry = (retry_q < RMAX);
  assign mismatch  = (rdata_q != expect_d);

  e2prom_wait_cnt #(.W(CNT_W)) u_gap (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .en    (state_q == WR_GAP),
    .value (CNT_W'(WR_WAIT_CYC)),
    .zero  (gap_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    go        = 1'b0;
    cnt_load  = 1'b0;
    i2c_exec  = 1'b0;
    i2c_rh_wl = I2C_WR;
    busy      = 1'b1;
    rw_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start || (AUTO_START && boot_q)) begin
          go      = 1'b1;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        i2c_exec = 1'b1;
        state_d  = WR_WAIT;
      end
      WR_WAIT: begin
        if (i2c_done) begin
          if (!i2c_ack || can_retry) begin
            cnt_load = 1'b1;
            state_d  = WR_GAP;
          end else begin
            state_d = DONE;
          end
        end
      end
      WR_GAP: begin
        if (gap_zero) begin
          state_d = (retry_q == 4'd0 && last) ? RD_REQ : WR_REQ;
        end
      end
      RD_REQ: begin
        i2c_exec  = 1'b1;
        i2c_rh_wl = I2C_RD;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        i2c_rh_wl = I2C_RD;
        if (i2c_done) begin
          if (!i2c_ack)       state_d = CHECK;
          else if (can_retry) state_d = RD_REQ;
          else                state_d = DONE;
        end
      end
      CHECK: begin
        i2c_rh_wl = I2C_RD;
        state_d   = last ? DONE : RD_REQ;
      end
      DONE: begin
        busy    = 1'b0;
        rw_done = 1'b1;
        if (start) begin
          go      = 1'b1;
          state_d = WR_REQ;
        end
      end
    endcase
  end

  assign i2c_addr   = busy ? addr : '0;
  assign i2c_data_w = (busy && !i2c_rh_wl) ? expect_d : 8'h00;

`ifdef E2PROM_BIST_ERRLOG_EN
  logic [ADDR_W-1:0] first_q;

  // Only the first failure (mismatch or abort) is recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= '0;
    end else if (go) begin
      first_q <= '0;
    end else if (err_q == 16'd0) begin
      if (state_q == CHECK && mismatch) begin
        first_q <= addr;
      end else if ((state_q == WR_WAIT || state_q == RD_WAIT)
                   && i2c_done && i2c_ack && !can_retry) begin
        first_q <= addr;
      end
    end
  end

  assign first_err_addr = first_q;
`else
  assign first_err_addr = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      retry_q  <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
      result_q <= 1'b0;
      boot_q   <= 1'b1;
    end else begin
      boot_q <= 1'b0;
      if (go) begin
        idx_q    <= '0;
        retry_q  <= '0;
        err_q    <= '0;
        result_q <= 1'b0;
      end
      case (state_q)
        WR_WAIT, RD_WAIT: begin
          if (i2c_done) begin
            if (!i2c_ack) begin
              retry_q <= '0;
              if (state_q == RD_WAIT) rdata_q <= i2c_data_r;
            end else if (can_retry) begin
              retry_q <= retry_q + 4'd1;
            end else begin
              result_q <= 1'b0;
            end
          end
        end
        WR_GAP: begin
          if (gap_zero && retry_q == 4'd0) begin
            idx_q <= last ? '0 : idx_q + 1'b1;
          end
        end
        CHECK: begin
          if (mismatch && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
          end
          if (last) result_q <= (err_q == 16'd0) && !mismatch;
          else      idx_q    <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rw_result = result_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_e2prom_bist.sv
// Self-checking bench for e2prom_bist: two instances (auto-start at 0x0010,
// manual start at 0xFFFE) against a behavioural EEPROM slave.
module tb_e2prom_bist;

  localparam int         NB   = 4;
  localparam int         WW   = 20;
  localparam int         MR   = 3;
  localparam logic [7:0] SEED = 8'h00;
  localparam bit         INV  = 1'b0;
`ifdef E2PROM_BIST_ERRLOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start[2];
  logic        exec[2];
  logic        rh_wl[2];
  logic        done[2];
  logic        ack[2];
  logic        busy[2];
  logic        rw_done[2];
  logic        rw_result[2];
  logic [15:0] addr[2];
  logic [15:0] err_cnt[2];
  logic [15:0] first_err[2];
  logic [7:0]  data_w[2];
  logic [7:0]  data_r[2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0]  mem[2][65536];
  bit          pend[2];
  bit          prd[2];
  int          lat[2];
  int          last_wd[2];
  logic [15:0] pa[2];
  logic [7:0]  pd[2];
  int          nack_addr[2];
  int          nack_left[2];
  int          corrupt_addr[2];
  bit          always_nack[2];
  int          exec_cnt[2];
  int          watch_cnt[2];
  int          ovl[2];
  int          min_gap[2];
  int          wn[2];
  int          rn[2];
  logic [15:0] wlog_a[2][16];
  logic [7:0]  wlog_d[2][16];
  logic [15:0] rlog_a[2][16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : gen
    e2prom_bist #(
      .ADDR_W      (16),
      .START_ADDR  (g == 0 ? 16'h0010 : 16'hFFFE),
      .NUM_BYTES   (NB),
      .SEED        (SEED),
      .PAT_INV     (INV),
      .WR_WAIT_CYC (WW),
      .MAX_RETRY   (MR),
      .AUTO_START  (g == 0)
    ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start[g]),
      .i2c_exec       (exec[g]),
      .i2c_rh_wl      (rh_wl[g]),
      .i2c_addr       (addr[g]),
      .i2c_data_w     (data_w[g]),
      .i2c_data_r     (data_r[g]),
      .i2c_done       (done[g]),
      .i2c_ack        (ack[g]),
      .busy           (busy[g]),
      .rw_done        (rw_done[g]),
      .rw_result      (rw_result[g]),
      .err_cnt        (err_cnt[g]),
      .first_err_addr (first_err[g])
    );
  end

  // EEPROM slave: random latency, scripted NACKs and read corruption.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        pend[g] = 1'b0;
        done[g] = 1'b0;
        ack[g] = 1'b0;
        last_wd[g] = -1;
      end else begin
        if (done[g]) begin
          done[g] = 1'b0;
          ack[g] = 1'b0;
        end
        if (exec[g] && pend[g]) ovl[g]++;
        if (pend[g]) begin
          if (lat[g] > 0) begin
            lat[g]--;
          end else begin
            pend[g] = 1'b0;
            done[g] = 1'b1;
            if (always_nack[g]) begin
              ack[g] = 1'b1;
            end else if (!prd[g] && int'(pa[g]) == nack_addr[g]
                         && nack_left[g] > 0) begin
              ack[g] = 1'b1;
              nack_left[g]--;
            end else if (!prd[g]) begin
              mem[g][pa[g]] = pd[g];
              if (wn[g] < 16) begin
                wlog_a[g][wn[g]] = pa[g];
                wlog_d[g][wn[g]] = pd[g];
              end
              wn[g]++;
            end else begin
              data_r[g] = (int'(pa[g]) == corrupt_addr[g]) ?
                          ~mem[g][pa[g]] : mem[g][pa[g]];
              if (rn[g] < 16) rlog_a[g][rn[g]] = pa[g];
              rn[g]++;
            end
            if (!prd[g]) last_wd[g] = cyc;
          end
        end else if (exec[g]) begin
          pend[g] = 1'b1;
          prd[g] = rh_wl[g];
          pa[g] = addr[g];
          pd[g] = data_w[g];
          lat[g] = int'($urandom_range(0, 3));
          exec_cnt[g]++;
          if (!prd[g] && int'(pa[g]) == nack_addr[g]) watch_cnt[g]++;
          if (!prd[g] && last_wd[g] >= 0
              && cyc - last_wd[g] < min_gap[g])
            min_gap[g] = cyc - last_wd[g];
        end
      end
    end
  end

  function automatic int sa(input int g);
    return (g == 0) ? 'h0010 : 'hFFFE;
  endfunction

  function automatic int ta(input int g, input int i);
    return (sa(g) + i) % 65536;
  endfunction

  function automatic logic [7:0] ep(input int a);
    int v;
    v = ((a % 256) + int'(SEED)) % 256;
    if (INV) v = 255 - v;
    return 8'(v);
  endfunction

  task automatic clr(input int g);
    wn[g] = 0;
    rn[g] = 0;
    exec_cnt[g] = 0;
    watch_cnt[g] = 0;
    min_gap[g] = 1000000;
    nack_addr[g] = -1;
    nack_left[g] = 0;
    corrupt_addr[g] = -1;
    always_nack[g] = 1'b0;
  endtask

  task automatic wait_run(input int g, input bit pulse, output bit ok);
    if (pulse) begin
      start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (rw_done[g]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    start[0] = 1'b0;
    start[1] = 1'b0;
    ovl[0] = 0;
    ovl[1] = 0;
    clr(0);
    clr(1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({busy[g], rw_done[g], rw_result[g], exec[g]} !== 4'b0) begin
        failures++;
        $display("FAIL reset_ctrl[%0d]: got %b expected 0000", g,
                 {busy[g], rw_done[g], rw_result[g], exec[g]});
      end
      checks++;
      if (err_cnt[g] !== 16'd0 || first_err[g] !== 16'd0) begin
        failures++;
        $display("FAIL reset_err[%0d]: got %h/%h expected 0/0", g,
                 err_cnt[g], first_err[g]);
      end
      checks++;
      if (addr[g] !== 16'd0 || data_w[g] !== 8'd0) begin
        failures++;
        $display("FAIL reset_bus[%0d]: got %h/%h expected 0/0", g,
                 addr[g], data_w[g]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_auto_pass();
    bit ok;
    wait_run(0, 1'b0, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL auto_timeout: got no rw_done expected rw_done");
    end
    checks++;
    if (rw_result[0] !== 1'b1 || err_cnt[0] !== 16'd0) begin
      failures++;
      $display("FAIL auto_result: got %b/%0d expected 1/0",
               rw_result[0], err_cnt[0]);
    end
    checks++;
    if (wn[0] != NB || rn[0] != NB) begin
      failures++;
      $display("FAIL auto_count: got w%0d r%0d expected %0d", wn[0],
               rn[0], NB);
    end
    for (int i = 0; i < NB && i < wn[0] && i < rn[0]; i++) begin
      checks++;
      if (int'(wlog_a[0][i]) != ta(0, i) || wlog_d[0][i] !== ep(ta(0, i))
          || int'(rlog_a[0][i]) != ta(0, i)) begin
        failures++;
        $display("FAIL auto_byte%0d: got %h:%h rd %h expected %h:%h", i,
                 wlog_a[0][i], wlog_d[0][i], rlog_a[0][i], ta(0, i),
                 ep(ta(0, i)));
      end
    end
    checks++;
    if (min_gap[0] < WW) begin
      failures++;
      $display("FAIL write_gap: got %0d expected >= %0d", min_gap[0], WW);
    end
    checks++;
    if (exec_cnt[1] != 0 || busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL no_autostart: got exec %0d busy %b expected 0 0",
               exec_cnt[1], busy[1]);
    end
  endtask

  task automatic test_corrupt();
    bit ok;
    clr(0);
    corrupt_addr[0] = 'h0012;
    wait_run(0, 1'b1, ok);
    checks++;
    if (!ok || rw_result[0] !== 1'b0 || err_cnt[0] !== 16'd1) begin
      failures++;
      $display("FAIL corrupt_result: got ok%b res%b err%0d expected 1 0 1",
               ok, rw_result[0], err_cnt[0]);
    end
    checks++;
    if (first_err[0] !== (LOG ? 16'h0012 : 16'h0000)) begin
      failures++;
      $display("FAIL corrupt_first: got %h expected %h", first_err[0],
               LOG ? 16'h0012 : 16'h0000);
    end
  endtask

  task automatic test_retry();
    bit ok;
    clr(0);
    nack_addr[0] = 'h0011;
    nack_left[0] = 2;
    wait_run(0, 1'b1, ok);
    checks++;
    if (watch_cnt[0] != 3) begin
      failures++;
      $display("FAIL retry_execs: got %0d expected 3", watch_cnt[0]);
    end
    checks++;
    if (!ok || rw_result[0] !== 1'b1 || exec_cnt[0] != 2 * NB + 2) begin
      failures++;
      $display("FAIL retry_result: got ok%b res%b exec%0d expected 1 1 %0d",
               ok, rw_result[0], exec_cnt[0], 2 * NB + 2);
    end
  endtask

  task automatic test_abort();
    bit ok;
    clr(0);
    always_nack[0] = 1'b1;
    wait_run(0, 1'b1, ok);
    checks++;
    if (!ok || exec_cnt[0] != MR + 1) begin
      failures++;
      $display("FAIL abort_execs: got ok%b exec%0d expected 1 %0d", ok,
               exec_cnt[0], MR + 1);
    end
    checks++;
    if (rw_result[0] !== 1'b0 || err_cnt[0] !== 16'd0
        || first_err[0] !== (LOG ? 16'h0010 : 16'h0000)) begin
      failures++;
      $display("FAIL abort_state: got res%b err%0d first%h expected 0 0 %h",
               rw_result[0], err_cnt[0], first_err[0],
               LOG ? 16'h0010 : 16'h0000);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    clr(1);
    wait_run(1, 1'b1, ok);
    checks++;
    if (!ok || rw_result[1] !== 1'b1 || wn[1] != NB) begin
      failures++;
      $display("FAIL wrap_result: got ok%b res%b w%0d expected 1 1 %0d",
               ok, rw_result[1], wn[1], NB);
    end
    for (int i = 0; i < NB && i < wn[1]; i++) begin
      checks++;
      if (int'(wlog_a[1][i]) != ta(1, i) || wlog_d[1][i] !== ep(ta(1, i)))
      begin
        failures++;
        $display("FAIL wrap_byte%0d: got %h:%h expected %h:%h", i,
                 wlog_a[1][i], wlog_d[1][i], ta(1, i), ep(ta(1, i)));
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int ci, ni, nn;
    int exp_err;
    int exp_first;
    for (int it = 0; it < 4; it++) begin
      clr(0);
      ci = int'($urandom_range(0, NB));
      ni = int'($urandom_range(0, NB - 1));
      nn = int'($urandom_range(0, MR));
      corrupt_addr[0] = (ci < NB) ? ta(0, ci) : -1;
      nack_addr[0] = ta(0, ni);
      nack_left[0] = nn;
      exp_err = (ci < NB) ? 1 : 0;
      exp_first = (LOG && ci < NB) ? ta(0, ci) : 0;
      wait_run(0, 1'b1, ok);
      checks++;
      if (!ok || int'(err_cnt[0]) != exp_err
          || rw_result[0] !== (exp_err == 0)) begin
        failures++;
        $display("FAIL rand%0d_result: got ok%b err%0d res%b expected 1 %0d",
                 it, ok, err_cnt[0], rw_result[0], exp_err);
      end
      checks++;
      if (int'(first_err[0]) != exp_first || watch_cnt[0] != nn + 1) begin
        failures++;
        $display("FAIL rand%0d_first: got %h/%0d expected %h/%0d", it,
                 first_err[0], watch_cnt[0], exp_first, nn + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit;
    clr(1);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (pend[1] && prd[1]) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL mid_reach_read: got no read expected read pending");
    end
    clr(0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy[1] !== 1'b0 || exec[1] !== 1'b0 || rh_wl[1] !== 1'b0) begin
      failures++;
      $display("FAIL mid_async: got busy%b exec%b rh%b expected 0 0 0",
               busy[1], exec[1], rh_wl[1]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exec_cnt[1] = 0;
    repeat (60) @(negedge clk);
    checks++;
    if (exec_cnt[1] != 0 || busy[1] !== 1'b0 || rw_done[1] !== 1'b0) begin
      failures++;
      $display("FAIL mid_idle: got exec%0d busy%b done%b expected 0 0 0",
               exec_cnt[1], busy[1], rw_done[1]);
    end
    checks++;
    if (rw_result[1] !== 1'b0 || err_cnt[1] !== 16'd0
        || addr[1] !== 16'd0 || first_err[1] !== 16'd0) begin
      failures++;
      $display("FAIL mid_outputs: got %b %h %h %h expected all 0",
               rw_result[1], err_cnt[1], addr[1], first_err[1]);
    end
    wait_run(0, 1'b0, ok);
    checks++;
    if (!ok || rw_result[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_autorerun: got ok%b res%b expected 1 1", ok,
               rw_result[0]);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clr(1);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL busy_level: got %b expected 1", busy[1]);
    end
    wait_run(1, 1'b1, ok);
    checks++;
    if (!ok || wn[1] != NB || exec_cnt[1] != 2 * NB) begin
      failures++;
      $display("FAIL busy_start: got ok%b w%0d exec%0d expected 1 %0d %0d",
               ok, wn[1], exec_cnt[1], NB, 2 * NB);
    end
    clr(1);
    wait_run(1, 1'b1, ok);
    checks++;
    if (!ok || wn[1] != NB || rw_result[1] !== 1'b1) begin
      failures++;
      $display("FAIL rerun: got ok%b w%0d res%b expected 1 %0d 1", ok,
               wn[1], rw_result[1], NB);
    end
    checks++;
    if (ovl[0] + ovl[1] != 0) begin
      failures++;
      $display("FAIL exec_overlap: got %0d expected 0", ovl[0] + ovl[1]);
    end
  endtask

  initial begin
    test_reset();
    test_auto_pass();
    test_corrupt();
    test_retry();
    test_abort();
    test_wrap();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
